// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: registered one-hot grant, owner index and master-lock
// qualifier, with burst and locked-transfer hold.
module ahb_arbiter #(
    parameter int MASTERS_NUM    = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW            = $clog2(MASTERS_NUM)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [MASTERS_NUM-1:0] HBUSREQ,
    input  logic [MASTERS_NUM-1:0] HLOCKx,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [MASTERS_NUM-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    localparam logic [MASTERS_NUM-1:0] DEF_GRANT = MASTERS_NUM'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    state_t                 state, state_nxt;
    logic [MW-1:0]          ptr, ptr_nxt;
    logic [MASTERS_NUM-1:0] grant_nxt;
    logic [MW-1:0]          hmaster_nxt;
    logic                   hmastlock_nxt;

    logic [MW-1:0]          owner;
    logic                   burst_hold, lock_hold, arb_point;
    logic                   win_found;
    logic [MW-1:0]          win_idx;

    function automatic logic [MW-1:0] oh2idx(input logic [MASTERS_NUM-1:0] v);
        logic [MW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MASTERS_NUM; i++)
            if (v[i]) idx = i[MW-1:0];
        return idx;
    endfunction

    // Scan ptr+1 .. ptr so the current owner comes last in the priority order.
    function automatic logic [MW:0] find_winner(input logic [MW-1:0]          p,
                                                input logic [MASTERS_NUM-1:0] req);
        logic          found;
        logic [MW-1:0] w;
        int unsigned   j;
        found = 1'b0;
        w     = p;
        for (int unsigned k = 1; k <= MASTERS_NUM; k++) begin
            j = (32'(p) + k) % MASTERS_NUM;
            if (!found && req[j]) begin
                found = 1'b1;
                w     = j[MW-1:0];
            end
        end
        return {found, w};
    endfunction

    assign owner      = oh2idx(HGRANT);
    assign burst_hold = (state == OWN) && ((HTRANS == TR_BUSY) || (HTRANS == TR_SEQ)) &&
                        HBUSREQ[owner];
    assign lock_hold  = (state == LOCK) && HLOCKx[owner];
    assign arb_point  = HREADY && !burst_hold && !lock_hold;
    assign {win_found, win_idx} = find_winner(ptr, HBUSREQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= PARK;
            ptr       <= DEF_IDX;
            HGRANT    <= DEF_GRANT;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            HGRANT    <= grant_nxt;
            HMASTER   <= hmaster_nxt;
            HMASTLOCK <= hmastlock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = HGRANT;
        if (arb_point) begin
            if (win_found) begin
                grant_nxt = MASTERS_NUM'(1) << win_idx;
                ptr_nxt   = win_idx;
                state_nxt = HLOCKx[win_idx] ? LOCK : OWN;
            end else begin
                grant_nxt = DEF_GRANT;
                state_nxt = PARK;
            end
        end
    end

    // Address-phase handover uses the pre-edge grant and state.
    always_comb begin
        hmaster_nxt   = HMASTER;
        hmastlock_nxt = HMASTLOCK;
        if (HREADY) begin
            hmaster_nxt   = owner;
            hmastlock_nxt = (state == LOCK);
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (4 masters, default master 0).
module tb_ahb_arbiter;

    localparam int N  = 4;
    localparam int MW = 2;

    logic          HCLK;
    logic          HRESETn;
    logic [N-1:0]  HBUSREQ;
    logic [N-1:0]  HLOCKx;
    logic [1:0]    HTRANS;
    logic          HREADY;
    logic [N-1:0]  HGRANT;
    logic [MW-1:0] HMASTER;
    logic          HMASTLOCK;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_arbiter #(.MASTERS_NUM(N), .DEFAULT_MASTER(0)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCKx   (HLOCKx),
        .HTRANS   (HTRANS),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] g,
                              input logic [MW-1:0] m, input logic l);
        check({tag, ".grant"}, 32'(HGRANT), 32'(g));
        check({tag, ".master"}, 32'(HMASTER), 32'(m));
        check({tag, ".lock"}, 32'(HMASTLOCK), 32'(l));
    endtask

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCKx  = '0;
        HTRANS  = IDLE;
        HREADY  = 1'b1;
        #23;
        HRESETn = 1'b1;
        #1;
        expect_out("reset", 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("reset_idle", 4'b0001, 2'd0, 1'b0);
        end

        // Round robin, HMASTER one cycle behind
        HBUSREQ = 4'b1111;
        HTRANS  = NONSEQ;
        tick(); expect_out("rr1", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("rr2", 4'b0100, 2'd1, 1'b0);
        tick(); expect_out("rr3", 4'b1000, 2'd2, 1'b0);
        tick(); expect_out("rr4", 4'b0001, 2'd3, 1'b0);
        tick(); expect_out("rr5", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("rr6", 4'b0100, 2'd1, 1'b0);

        // Burst hold on master 2
        HTRANS = SEQ;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("burst", 4'b0100, 2'd2, 1'b0);
        end
        HTRANS = IDLE;
        tick(); expect_out("burst_end", 4'b1000, 2'd2, 1'b0);

        // Owner drops request mid-SEQ: arbitration point
        HTRANS  = SEQ;
        HBUSREQ = 4'b0111;
        tick(); expect_out("seq_drop", 4'b0001, 2'd3, 1'b0);
        HTRANS  = NONSEQ;
        HBUSREQ = 4'b1111;

        // Locked transfer by master 1
        HLOCKx = 4'b0010;
        tick(); expect_out("lock_grant", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("lock_hold1", 4'b0010, 2'd1, 1'b1);
        tick(); expect_out("lock_hold2", 4'b0010, 2'd1, 1'b1);
        HLOCKx = 4'b0000;
        tick(); expect_out("lock_rel", 4'b0100, 2'd1, 1'b1);
        tick(); expect_out("lock_after", 4'b1000, 2'd2, 1'b0);

        // Lock from a non-winner is ignored
        HLOCKx = 4'b0100;
        tick(); expect_out("lock_nonwin", 4'b0001, 2'd3, 1'b0);
        HLOCKx = 4'b0000;

        // Wait states freeze everything
        HREADY  = 1'b0;
        HBUSREQ = 4'b0100; tick(); expect_out("wait1", 4'b0001, 2'd3, 1'b0);
        HBUSREQ = 4'b0010; tick(); expect_out("wait2", 4'b0001, 2'd3, 1'b0);
        HBUSREQ = 4'b1000; tick(); expect_out("wait3", 4'b0001, 2'd3, 1'b0);
        HREADY  = 1'b1;
        tick(); expect_out("wait_end", 4'b1000, 2'd0, 1'b0);

        // Park, pointer kept at 3
        HBUSREQ = 4'b0000;
        tick(); expect_out("park1", 4'b0001, 2'd3, 1'b0);
        tick(); expect_out("park2", 4'b0001, 2'd0, 1'b0);
        HBUSREQ = 4'b0011;
        tick(); expect_out("park_ptr", 4'b0001, 2'd0, 1'b0);

        // Async reset during LOCK; ptr is 0 so master 1 wins
        HBUSREQ = 4'b1111;
        HLOCKx  = 4'b0010;
        tick(); expect_out("lock2_grant", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("lock2_hold", 4'b0010, 2'd1, 1'b1);
        #1;
        HRESETn = 1'b0;
        #1;
        expect_out("async_reset", 4'b0001, 2'd0, 1'b0);
        tick(); expect_out("reset_held", 4'b0001, 2'd0, 1'b0);
        HLOCKx  = 4'b0000;
        HRESETn = 1'b1;
        tick(); expect_out("post_reset", 4'b0010, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
